// File: rtl/floor_request_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : floor_request_scheduler_pkg
// Description : Shared floor-count defaults and scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package floor_request_scheduler_pkg;

   localparam int FRS_NUM_FLOORS = 4;
   localparam int FRS_FLOOR_W    = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_UP    = 2'd1,
      S_DOWN  = 2'd2,
      S_SERVE = 2'd3
   } state_e;

endpackage : floor_request_scheduler_pkg
`default_nettype wire

// File: rtl/floor_request_scheduler_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Synchronise, debounce and rising-edge detect one raw button.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic press
);

   localparam int                 c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic               sync1_q, sync2_q;
   logic               level_q, level_d;
   logic               press_q, press_d;
   logic [c_CNT_W-1:0] cnt_q, cnt_d;

   // The pulse is registered alongside the level toggle so it fires on the
   // same edge the new level is accepted.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == c_LAST) begin
            level_d = ~level_q;
            press_d = ~level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press = press_q;

endmodule : button_conditioner
`default_nettype wire

// File: rtl/floor_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : floor_request_scheduler
// Description : Button conditioning, pending-call register and SCAN scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module floor_request_scheduler
   import floor_request_scheduler_pkg::*;
#(
   parameter int NUM_FLOORS      = FRS_NUM_FLOORS,
   parameter int FLOOR_W         = FRS_FLOOR_W,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [NUM_FLOORS-1:0] cab_btn,
   input  logic [NUM_FLOORS-1:0] hall_btn,
   input  logic [FLOOR_W-1:0]    cur_floor,
   input  logic                  floor_arrive,
   input  logic                  door_done,
   output logic [NUM_FLOORS-1:0] pending,
   output logic [FLOOR_W-1:0]    target_floor,
   output logic                  move_req,
   output logic                  dir_up,
   output logic                  door_open
);

   logic [2*NUM_FLOORS-1:0] w_raw, w_press;
   logic [NUM_FLOORS-1:0]   w_req, w_set, w_clr, w_cur_onehot, w_above, w_below;
   logic                    w_any_above, w_any_below, w_pend_cur;
   logic [FLOOR_W-1:0]      w_tgt_up, w_tgt_down;

   state_e                  state_q, state_d;
   logic [NUM_FLOORS-1:0]   pending_q, pending_d;
   logic [FLOOR_W-1:0]      target_q, target_d;
   logic                    move_req_q, move_req_d;
   logic                    dir_up_q, dir_up_d;
   logic                    door_open_q, door_open_d;

   assign w_raw = {hall_btn, cab_btn};

   for (genvar g = 0; g < 2*NUM_FLOORS; g++) begin : g_btn
      button_conditioner #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cond (
         .clk    (clk),
         .rst_n  (reset),
         .btn_raw(w_raw[g]),
         .press  (w_press[g])
      );
   end

   assign w_req = w_press[NUM_FLOORS-1:0] | w_press[2*NUM_FLOORS-1:NUM_FLOORS];

   always_comb begin
      w_cur_onehot = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << cur_floor;
      w_above      = '0;
      w_below      = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (i > int'(cur_floor)) w_above[i] = 1'b1;
         if (i < int'(cur_floor)) w_below[i] = 1'b1;
      end
      w_any_above = |(pending_q & w_above);
      w_any_below = |(pending_q & w_below);
      w_pend_cur  = |(pending_q & w_cur_onehot);

      // Descending scan keeps the lowest hit above; ascending keeps the highest below.
      w_tgt_up = cur_floor;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending_q[i] && w_above[i]) w_tgt_up = FLOOR_W'(i);
      end
      w_tgt_down = cur_floor;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending_q[i] && w_below[i]) w_tgt_down = FLOOR_W'(i);
      end
   end

   always_comb begin
      w_set = w_req;
      if (state_q == S_SERVE) w_set = w_req & ~w_cur_onehot;
      w_clr = (state_q == S_SERVE && door_done) ? w_cur_onehot : '0;
      pending_d = enable ? ((pending_q | w_set) & ~w_clr) : pending_q;
   end

   always_comb begin
      state_d  = state_q;
      dir_up_d = dir_up_q;
      if (enable) begin
         case (state_q)
            S_IDLE: begin
               if (w_pend_cur) begin
                  state_d = S_SERVE;
               end else if (w_any_above) begin
                  state_d  = S_UP;
                  dir_up_d = 1'b1;
               end else if (w_any_below) begin
                  state_d  = S_DOWN;
                  dir_up_d = 1'b0;
               end
            end
            S_UP: begin
               if (floor_arrive && w_pend_cur) state_d = S_SERVE;
               else if (!w_any_above)          state_d = S_IDLE;
            end
            S_DOWN: begin
               if (floor_arrive && w_pend_cur) state_d = S_SERVE;
               else if (!w_any_below)          state_d = S_IDLE;
            end
            S_SERVE: begin
               // Above/below masks already exclude cur_floor, so the call being served never counts.
               if (door_done) begin
                  if (dir_up_q && w_any_above) begin
                     state_d = S_UP;
                  end else if (!dir_up_q && w_any_below) begin
                     state_d = S_DOWN;
                  end else if (w_any_above) begin
                     state_d  = S_UP;
                     dir_up_d = 1'b1;
                  end else if (w_any_below) begin
                     state_d  = S_DOWN;
                     dir_up_d = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      move_req_d  = (state_d == S_UP) || (state_d == S_DOWN);
      door_open_d = (state_d == S_SERVE);
      if (!enable)                 target_d = target_q;
      else if (state_d == S_UP)    target_d = w_tgt_up;
      else if (state_d == S_DOWN)  target_d = w_tgt_down;
      else                         target_d = cur_floor;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         pending_q   <= '0;
         target_q    <= '0;
         move_req_q  <= 1'b0;
         dir_up_q    <= 1'b0;
         door_open_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         target_q    <= target_d;
         move_req_q  <= move_req_d;
         dir_up_q    <= dir_up_d;
         door_open_q <= door_open_d;
      end
   end

   assign pending      = pending_q;
   assign target_floor = target_q;
   assign move_req     = move_req_q;
   assign dir_up       = dir_up_q;
   assign door_open    = door_open_q;

endmodule : floor_request_scheduler
`default_nettype wire

// File: tb/tb_floor_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_floor_request_scheduler
// Description : Directed self-checking bench for floor_request_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floor_request_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [3:0] cab_btn, hall_btn;
   logic [1:0] cur_floor;
   logic       floor_arrive, door_done;
   logic [3:0] pending;
   logic [1:0] target_floor;
   logic       move_req, dir_up, door_open;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [3:0] exp_q[$];

   floor_request_scheduler #(
      .NUM_FLOORS(4), .FLOOR_W(2), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .cab_btn(cab_btn), .hall_btn(hall_btn), .cur_floor(cur_floor),
      .floor_arrive(floor_arrive), .door_done(door_done),
      .pending(pending), .target_floor(target_floor), .move_req(move_req),
      .dir_up(dir_up), .door_open(door_open)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Pops the scoreboard once pending moves off its old value (bounded wait).
   task automatic wait_pending(input string tag, input logic [3:0] prev);
      int n = 0;
      logic [3:0] e;
      while (pending === prev && n < 20) begin
         step(1);
         n++;
      end
      e = exp_q.pop_front();
      chk(tag, 32'(pending), 32'(e));
   endtask

   task automatic pulse_arrive(input logic [1:0] f);
      cur_floor    = f;
      floor_arrive = 1'b1;
      step(1);
      floor_arrive = 1'b0;
   endtask

   task automatic pulse_done();
      door_done = 1'b1;
      step(1);
      door_done = 1'b0;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b1; cab_btn = '0; hall_btn = '0;
      cur_floor = 2'd0; floor_arrive = 1'b0; door_done = 1'b0;
      step(2);
      chk("rst_pending",  32'(pending),      32'h0);
      chk("rst_target",   32'(target_floor), 32'h0);
      chk("rst_move",     32'(move_req),     32'h0);
      chk("rst_dir",      32'(dir_up),       32'h0);
      chk("rst_door",     32'(door_open),    32'h0);
      reset = 1'b1;
      step(2);

      // Bounce rejection
      hall_btn[2] = 1'b1; step(3);
      hall_btn[2] = 1'b0; step(2);
      hall_btn[2] = 1'b1; step(3);
      hall_btn[2] = 1'b0; step(12);
      chk("bounce_pending", 32'(pending),  32'h0);
      chk("bounce_move",    32'(move_req), 32'h0);

      // Basic up call with exact latency
      exp_q.push_back(4'b1000);
      cab_btn[3] = 1'b1;
      step(6);
      chk("lat_early", 32'(pending), 32'h0);
      step(1);
      chk("lat_pending", 32'(pending), 32'(exp_q.pop_front()));
      step(1);
      cab_btn[3] = 1'b0;
      chk("up_move",   32'(move_req),     32'h1);
      chk("up_dir",    32'(dir_up),       32'h1);
      chk("up_target", 32'(target_floor), 32'h3);
      chk("up_door",   32'(door_open),    32'h0);

      // Retarget to a nearer call
      exp_q.push_back(4'b1010);
      hall_btn[1] = 1'b1;
      wait_pending("retgt_pending", 4'b1000);
      step(1);
      hall_btn[1] = 1'b0;
      chk("retgt_target", 32'(target_floor), 32'h1);
      step(8);
      pulse_arrive(2'd1);
      chk("arr1_door", 32'(door_open), 32'h1);
      chk("arr1_move", 32'(move_req),  32'h0);
      pulse_done();
      chk("done1_pending", 32'(pending),      32'h8);
      chk("done1_move",    32'(move_req),     32'h1);
      chk("done1_dir",     32'(dir_up),       32'h1);
      chk("done1_target",  32'(target_floor), 32'h3);

      // Call behind the car does not retarget
      exp_q.push_back(4'b1001);
      cab_btn[0] = 1'b1;
      wait_pending("behind_pending", 4'b1000);
      step(1);
      cab_btn[0] = 1'b0;
      chk("behind_target", 32'(target_floor), 32'h3);
      step(8);

      // Reversal at the top floor
      pulse_arrive(2'd3);
      chk("arr3_door", 32'(door_open), 32'h1);
      pulse_done();
      chk("rev_pending", 32'(pending),      32'h1);
      chk("rev_dir",     32'(dir_up),       32'h0);
      chk("rev_target",  32'(target_floor), 32'h0);
      chk("rev_move",    32'(move_req),     32'h1);

      // floor_arrive at a floor with no call keeps moving
      pulse_arrive(2'd2);
      chk("pass2_move", 32'(move_req),  32'h1);
      chk("pass2_door", 32'(door_open), 32'h0);
      pulse_arrive(2'd0);
      pulse_done();
      chk("idle_pending", 32'(pending),   32'h0);
      chk("idle_move",    32'(move_req),  32'h0);
      chk("idle_door",    32'(door_open), 32'h0);
      chk("idle_dir",     32'(dir_up),    32'h0);

      // Same-floor call
      cur_floor = 2'd2;
      step(1);
      exp_q.push_back(4'b0100);
      cab_btn[2] = 1'b1;
      wait_pending("same_pending", 4'b0000);
      cab_btn[2] = 1'b0;
      step(1);
      chk("same_door", 32'(door_open), 32'h1);
      chk("same_move", 32'(move_req),  32'h0);
      step(8);
      cab_btn[2] = 1'b1; step(10);
      cab_btn[2] = 1'b0; step(10);
      chk("same_hold", 32'(pending), 32'h4);
      pulse_done();
      chk("same_cleared", 32'(pending),   32'h0);
      chk("same_closed",  32'(door_open), 32'h0);

      // enable=0 drops presses and ignores door_done
      enable = 1'b0;
      cab_btn[1] = 1'b1; step(10);
      cab_btn[1] = 1'b0; step(10);
      chk("dis_pending", 32'(pending),  32'h0);
      chk("dis_move",    32'(move_req), 32'h0);
      enable = 1'b1;
      step(2);

      // Reset mid-move
      cur_floor = 2'd1;
      step(1);
      exp_q.push_back(4'b1100);
      cab_btn[2] = 1'b1; cab_btn[3] = 1'b1;
      wait_pending("mv_pending", 4'b0000);
      cab_btn[2] = 1'b0; cab_btn[3] = 1'b0;
      step(1);
      chk("mv_move",   32'(move_req),     32'h1);
      chk("mv_target", 32'(target_floor), 32'h2);
      #3 reset = 1'b0;
      #1;
      chk("arst_pending", 32'(pending),      32'h0);
      chk("arst_target",  32'(target_floor), 32'h0);
      chk("arst_move",    32'(move_req),     32'h0);
      chk("arst_dir",     32'(dir_up),       32'h0);
      chk("arst_door",    32'(door_open),    32'h0);
      step(2);
      reset = 1'b1;
      step(12);
      chk("post_pending", 32'(pending),  32'h0);
      chk("post_move",    32'(move_req), 32'h0);
      chk("post_door",    32'(door_open), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_floor_request_scheduler
`default_nettype wire

// File: doc/floor_request_scheduler.md
Name: floor_request_scheduler

Overview:
Upstream stage of the elevator controller. It conditions the raw cabin and hall call buttons (synchronise, debounce, edge-detect) and holds one pending-call bit per floor. A SCAN-style FSM picks the next target floor and travel direction from the current floor. Its target_floor, dir_up and door_open outputs drive the controller's solicitud, SubeBaja and AbreCierra paths.

Parameters:
NUM_FLOORS, 4, number of floors, indexed 0..NUM_FLOORS-1
FLOOR_W, 2, width of floor numbers; must equal clog2(NUM_FLOORS)
DEBOUNCE_CYCLES, 4, consecutive stable samples needed to accept a button level change

Ports:
clk  in  1  system clock; every flop is on the rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  when 0, press pulses are dropped and the FSM holds its state
cab_btn  in  NUM_FLOORS  raw cabin buttons, asynchronous, one per floor
hall_btn  in  NUM_FLOORS  raw hall call buttons, asynchronous, one per floor
cur_floor  in  FLOOR_W  current floor reported by the controller
floor_arrive  in  1  1-cycle pulse: the car has reached cur_floor
door_done  in  1  1-cycle pulse: the door cycle at the current floor is complete
pending  out  NUM_FLOORS  latched call bits
target_floor  out  FLOOR_W  floor currently being headed to
move_req  out  1  1 while the state is UP or DOWN
dir_up  out  1  1 = up, 0 = down; holds its last value in IDLE and SERVE
door_open  out  1  1 while the state is SERVE

Behaviour:
- Reset (reset=0, asynchronous): all sync, debounce and counter flops clear; pending=0, target_floor=0, move_req=0, dir_up=0, door_open=0, state=IDLE.
- Conditioning, applied per raw button:
  - 2-flop synchroniser, then a counter. The counter increments while the synchronised sample differs from the debounced level and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - A debounced 0->1 transition produces a 1-cycle press pulse.
  - Latency from a stable raw rise to the press pulse: 2+DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES samples never produce a pulse.
- pending[i] update:
  - Set on the cycle after a press pulse from cab_btn[i] or hall_btn[i], if enable=1.
  - A press for cur_floor while state=SERVE is absorbed (not set).
  - Cleared on the cycle after door_done while in SERVE, for i=cur_floor.
  - If a set and a clear for the same bit coincide, clear wins.
- FSM states: IDLE, UP, DOWN, SERVE. Transitions are evaluated on registered pending and take 1 cycle.
  - IDLE, pending[cur_floor]=1: go to SERVE.
  - IDLE, any pending bit above cur_floor: go to UP, dir_up=1. This takes priority over calls below.
  - IDLE, any pending bit below cur_floor: go to DOWN, dir_up=0.
  - UP/DOWN, floor_arrive with pending[cur_floor]=1: go to SERVE. Otherwise keep moving.
  - SERVE, door_done: direction is resolved against pending with bit cur_floor excluded.
    - If a call remains in the dir_up direction, return to UP or DOWN in that direction.
    - Else if a call remains in the opposite direction, reverse (dir_up toggles).
    - Else go to IDLE.
- target_floor:
  - UP: lowest pending floor above cur_floor.
  - DOWN: highest pending floor below cur_floor.
  - IDLE/SERVE: cur_floor.
  - Registered; updates the cycle after pending changes, so a mid-route call closer in the travel direction retargets immediately.
- Boundaries:
  - UP with nothing above (unreachable by design): go to IDLE.
  - cur_floor=0 has no "below"; cur_floor=NUM_FLOORS-1 has no "above".
  - floor_arrive outside UP/DOWN is ignored; door_done outside SERVE is ignored.
- enable=0: conditioning keeps running but press pulses are discarded. FSM state, pending and outputs are frozen. floor_arrive and door_done are ignored.
- Reset asserted mid-operation: everything returns to its reset value immediately, and pending calls are lost.

Decomposition:
- Shared package/header holds:
  - The FSM state encoding: IDLE=2'd0, UP=2'd1, DOWN=2'd2, SERVE=2'd3.
  - NUM_FLOORS and FLOOR_W defaults, shared with the elevator controller.
- Sub-module button_conditioner: synchroniser, debounce counter and edge detector for one button, parameterised by DEBOUNCE_CYCLES. It is instantiated 2*NUM_FLOORS times with a generate loop.
- FSM, pending register and target selection live in the top module.

Test Plan:
1. Bounce rejection: hall_btn[2] high for 3 cycles, low for 2, high for 3 (DEBOUNCE_CYCLES=4) -> pending stays 4'b0000, move_req=0.
2. Basic up call: cur_floor=0, cab_btn[3] held high -> press pulse at cycle 6, pending=4'b1000 at cycle 7, then move_req=1, dir_up=1, target_floor=3.
3. Retarget: while UP toward floor 3, press hall_btn[1] -> target_floor=1. Then cur_floor=1 with floor_arrive -> door_open=1 next cycle. Then door_done -> pending=4'b1000, state UP, target_floor=3.
4. Reversal: at cur_floor=3 in SERVE with pending=4'b1001, door_done -> pending=4'b0001, dir_up=0, target_floor=0, move_req=1.
5. Same-floor call: IDLE with cur_floor=2, press cab_btn[2] -> SERVE, door_open=1, move_req=0. A second press during SERVE leaves pending[2]=0 after door_done.
6. Reset mid-move: assert reset=0 while in UP with pending=4'b1100 -> all outputs 0 asynchronously; after release, state IDLE, pending 0.
